serv_alu_seq: RTL and testbench

//  Self-sequenced W-bit-per-beat ALU for the SERV datapath. Processes one XLEN-bit operation
//  as XLEN/W beats, owning its own beat counter, carry and compare state instead of relying on

---
 rtl/serv_alu_seq_if.sv | 39 +++
 rtl/serv_alu_seq.sv | 142 ++++++++++++++
 tb/tb_serv_alu_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serv_alu_seq_if.sv
// Bundle of control, operand-beat and status signals between the SERV operand
// buffers / register-file writer and the sequenced ALU.
interface serv_alu_seq_if #(
   parameter int W = 4
);
   // i_start is accepted only in IDLE or DONE (ignored in RUN); i_en marks a valid
   // input beat in RUN, and o_rd is valid combinationally in that same cycle with no
   // backpressure; o_done pulses for one cycle and o_cmp is valid from then on.
   logic         i_start;
   logic         i_flush;
   logic         i_sub;
   logic [1:0]   i_bool_op;
   logic         i_cmp_eq;
   logic         i_cmp_sig;
   logic [2:0]   i_rd_sel;
   logic         i_en;
   logic [W-1:0] i_rs1;
   logic [W-1:0] i_op_b;
   logic [W-1:0] i_buf;
   logic [W-1:0] o_rd;
   logic         o_busy;
   logic         o_cnt0;
   logic         o_last;
   logic         o_done;
   logic         o_cmp;
   logic [1:0]   o_state;

   modport master (
      output i_start, i_flush, i_sub, i_bool_op, i_cmp_eq, i_cmp_sig, i_rd_sel,
             i_en, i_rs1, i_op_b, i_buf,
      input  o_rd, o_busy, o_cnt0, o_last, o_done, o_cmp, o_state
   );

   modport slave (
      input  i_start, i_flush, i_sub, i_bool_op, i_cmp_eq, i_cmp_sig, i_rd_sel,
             i_en, i_rs1, i_op_b, i_buf,
      output o_rd, o_busy, o_cnt0, o_last, o_done, o_cmp, o_state
   );
endinterface

// File: rtl/serv_alu_seq.sv
// Self-sequenced W-bit-per-beat ALU: walks one XLEN-bit add/sub/compare/bool op
// over XLEN/W beats, keeping its own beat counter, carry and compare state.
module serv_alu_seq #(
   parameter int W    = 4,
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         i_rst_n,
   serv_alu_seq_if.slave bus
);
   localparam int BEATS = XLEN / W;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            carry_q, carry_d;
   logic            eq_q, eq_d;
   logic            cmp_q, cmp_d;
   logic            sub_q, sub_d;
   logic [1:0]      bool_op_q, bool_op_d;
   logic            cmp_eq_q, cmp_eq_d;
   logic            cmp_sig_q, cmp_sig_d;
   logic [2:0]      rd_sel_q, rd_sel_d;

   logic [W-1:0]    add_b;
   logic [W-1:0]    sum;
   logic            cy;
   logic            eq_now;
   logic            lt;
   logic            beat;
   logic            last_beat;
   logic            cnt0;
   logic [W-1:0]    slt;
   logic [W-1:0]    bool_res;

   always_comb begin
      add_b       = bus.i_op_b ^ {W{sub_q}};
      {cy, sum}   = {1'b0, bus.i_rs1} + {1'b0, add_b} + {{W{1'b0}}, carry_q};
      eq_now      = eq_q & (sum == '0);
      // Sign-extended top bit of rs1 - op_b; the carry-in is the chained carry.
      lt          = (bus.i_rs1[W-1] & cmp_sig_q) ^ ~(bus.i_op_b[W-1] & cmp_sig_q) ^ cy;
      beat        = (state_q == RUN) & bus.i_en;
      last_beat   = (cnt_q == CW'(BEATS - 1));
      cnt0        = (state_q == RUN) & (cnt_q == '0);
      slt         = '0;
      slt[0]      = cmp_q & cnt0;
      bool_res    = ((bus.i_rs1 ^ bus.i_op_b) & ~{W{bool_op_q[0]}}) |
                    ({W{bool_op_q[1]}} & bus.i_rs1 & bus.i_op_b);
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      carry_d   = carry_q;
      eq_d      = eq_q;
      cmp_d     = cmp_q;
      sub_d     = sub_q;
      bool_op_d = bool_op_q;
      cmp_eq_d  = cmp_eq_q;
      cmp_sig_d = cmp_sig_q;
      rd_sel_d  = rd_sel_q;

      if (bus.i_flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (bus.i_en) begin
                  carry_d = cy;
                  eq_d    = eq_now;
                  if (last_beat) begin
                     cmp_d   = cmp_eq_q ? eq_now : lt;
                     state_d = DONE;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            default: begin
               // IDLE and DONE both accept a start; DONE otherwise falls back to IDLE.
               if (bus.i_start) begin
                  state_d   = RUN;
                  cnt_d     = '0;
                  carry_d   = bus.i_sub;
                  eq_d      = 1'b1;
                  sub_d     = bus.i_sub;
                  bool_op_d = bus.i_bool_op;
                  cmp_eq_d  = bus.i_cmp_eq;
                  cmp_sig_d = bus.i_cmp_sig;
                  rd_sel_d  = bus.i_rd_sel;
               end else begin
                  state_d = IDLE;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         eq_q      <= 1'b1;
         cmp_q     <= 1'b0;
         sub_q     <= 1'b0;
         bool_op_q <= 2'b00;
         cmp_eq_q  <= 1'b0;
         cmp_sig_q <= 1'b0;
         rd_sel_q  <= 3'b000;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         carry_q   <= carry_d;
         eq_q      <= eq_d;
         cmp_q     <= cmp_d;
         sub_q     <= sub_d;
         bool_op_q <= bool_op_d;
         cmp_eq_q  <= cmp_eq_d;
         cmp_sig_q <= cmp_sig_d;
         rd_sel_q  <= rd_sel_d;
      end
   end

   assign bus.o_rd    = {W{beat}} & (bus.i_buf |
                                     ({W{rd_sel_q[0]}} & sum) |
                                     ({W{rd_sel_q[1]}} & slt) |
                                     ({W{rd_sel_q[2]}} & bool_res));
   assign bus.o_busy  = (state_q == RUN);
   assign bus.o_cnt0  = cnt0;
   assign bus.o_last  = (state_q == RUN) & last_beat;
   assign bus.o_done  = (state_q == DONE);
   assign bus.o_cmp   = cmp_q;
   assign bus.o_state = state_q;
endmodule

// File: tb/tb_serv_alu_seq.sv
// Directed bench for serv_alu_seq (W=4, XLEN=32): vector table plus hand-written
// flush, back-to-back and mid-operation reset sequences.
module tb_serv_alu_seq;
   localparam int W     = 4;
   localparam int XLEN  = 32;
   localparam int BEATS = XLEN / W;

   logic clk;
   logic i_rst_n;
   int   checks;
   int   errors;

   serv_alu_seq_if #(.W(W)) bus ();

   serv_alu_seq #(.W(W), .XLEN(XLEN)) dut (
      .clk     (clk),
      .i_rst_n (i_rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sub;
      logic [1:0]  bop;
      logic        ceq;
      logic        csig;
      logic [2:0]  rsel;
      logic [31:0] rs1;
      logic [31:0] opb;
      logic [31:0] bufw;
      logic [31:0] exp_rd;
      logic        exp_cmp;
      logic        stall;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_beat(input vec_t v, input int b);
      bus.i_rs1  = v.rs1[b*W +: W];
      bus.i_op_b = v.opb[b*W +: W];
      bus.i_buf  = v.bufw[b*W +: W];
   endtask

   // Called at a negedge in IDLE or DONE; returns at the negedge of the first RUN cycle.
   task automatic start_op(input vec_t v, input string tag);
      bus.i_start   = 1'b1;
      bus.i_sub     = v.sub;
      bus.i_bool_op = v.bop;
      bus.i_cmp_eq  = v.ceq;
      bus.i_cmp_sig = v.csig;
      bus.i_rd_sel  = v.rsel;
      bus.i_en      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.i_start   = 1'b0;
      bus.i_sub     = 1'b0;
      bus.i_bool_op = 2'b00;
      bus.i_cmp_eq  = 1'b0;
      bus.i_cmp_sig = 1'b0;
      bus.i_rd_sel  = 3'b000;
      #1;
      chk({tag, " busy after start"}, 32'(bus.o_busy), 32'd1);
      chk({tag, " cnt0 after start"}, 32'(bus.o_cnt0), 32'd1);
   endtask

   // Feeds all beats (optionally with random stalls); returns at negedge+1 of the DONE cycle.
   task automatic run_beats(input vec_t v, input string tag);
      logic [31:0] got;
      int          b;
      int          guard;
      got   = '0;
      b     = 0;
      guard = 0;
      while (b < BEATS && guard < 200) begin
         bus.i_en = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
         drive_beat(v, b);
         #1;
         if (bus.i_en) begin
            got[b*W +: W] = bus.o_rd;
            chk($sformatf("%s cnt0 beat%0d", tag, b), 32'(bus.o_cnt0), 32'(b == 0));
            chk($sformatf("%s last beat%0d", tag, b), 32'(bus.o_last), 32'(b == BEATS - 1));
            b++;
         end else begin
            chk($sformatf("%s stalled rd beat%0d", tag, b), 32'(bus.o_rd), 32'd0);
         end
         @(posedge clk);
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) chk({tag, " beat timeout"}, 32'(guard), 32'd0);
      bus.i_en   = 1'b0;
      bus.i_rs1  = '0;
      bus.i_op_b = '0;
      bus.i_buf  = '0;
      #1;
      chk({tag, " rd word"}, got, v.exp_rd);
      chk({tag, " done"}, 32'(bus.o_done), 32'd1);
      chk({tag, " busy at done"}, 32'(bus.o_busy), 32'd0);
      chk({tag, " cmp"}, 32'(bus.o_cmp), 32'(v.exp_cmp));
   endtask

   task automatic idle_after(input string tag);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk({tag, " done pulse ends"}, 32'(bus.o_done), 32'd0);
      chk({tag, " idle state"}, 32'(bus.o_state), 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      //          sub  bop    ceq   csig  rsel    rs1           opb           buf           exp_rd        cmp   stall
      vecs[0]  = '{1'b0, 2'b00, 1'b0, 1'b0, 3'b001, 32'h0000_FFFF, 32'h0000_0001, 32'h0,        32'h0001_0000, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 2'b00, 1'b1, 1'b0, 3'b000, 32'h1234_5678, 32'h1234_5678, 32'h0,        32'h0,         1'b1, 1'b0};
      vecs[2]  = '{1'b1, 2'b00, 1'b1, 1'b0, 3'b000, 32'h1234_5679, 32'h1234_5678, 32'h0,        32'h0,         1'b0, 1'b0};
      vecs[3]  = '{1'b1, 2'b00, 1'b0, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,        32'h0,         1'b0, 1'b0};
      vecs[4]  = '{1'b1, 2'b00, 1'b0, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,        32'h0,         1'b1, 1'b0};
      vecs[5]  = '{1'b1, 2'b00, 1'b0, 1'b1, 3'b010, 32'h0000_0005, 32'h0000_0003, 32'h0,        32'h0000_0001, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 2'b11, 1'b0, 1'b0, 3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,        32'hF000_F000, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 2'b00, 1'b0, 1'b0, 3'b100, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0,        32'h1D3B_5977, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 2'b10, 1'b0, 1'b0, 3'b100, 32'h0000_00F0, 32'h0000_000F, 32'h0,        32'h0000_00FF, 1'b1, 1'b0};
      vecs[9]  = '{1'b0, 2'b00, 1'b0, 1'b0, 3'b000, 32'h0,         32'h0,         32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 2'b01, 1'b0, 1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0,        32'h0,         1'b0, 1'b0};
      vecs[11] = '{1'b1, 2'b00, 1'b0, 1'b0, 3'b001, 32'h0000_0010, 32'h0000_0020, 32'h0,        32'hFFFF_FFF0, 1'b1, 1'b0};

      i_rst_n       = 1'b0;
      bus.i_start   = 1'b0;
      bus.i_flush   = 1'b0;
      bus.i_sub     = 1'b0;
      bus.i_bool_op = 2'b00;
      bus.i_cmp_eq  = 1'b0;
      bus.i_cmp_sig = 1'b0;
      bus.i_rd_sel  = 3'b000;
      bus.i_en      = 1'b1;
      bus.i_rs1     = 4'hF;
      bus.i_op_b    = 4'hF;
      bus.i_buf     = 4'hF;
      repeat (3) @(negedge clk);
      i_rst_n = 1'b1;
      #1;
      chk("reset rd", 32'(bus.o_rd), 32'd0);
      chk("reset busy", 32'(bus.o_busy), 32'd0);
      chk("reset cnt0", 32'(bus.o_cnt0), 32'd0);
      chk("reset last", 32'(bus.o_last), 32'd0);
      chk("reset done", 32'(bus.o_done), 32'd0);
      chk("reset cmp", 32'(bus.o_cmp), 32'd0);
      chk("reset state", 32'(bus.o_state), 32'd0);
      bus.i_en   = 1'b0;
      bus.i_rs1  = '0;
      bus.i_op_b = '0;
      bus.i_buf  = '0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         start_op(vecs[i], $sformatf("vec%0d", i));
         run_beats(vecs[i], $sformatf("vec%0d", i));
         idle_after($sformatf("vec%0d", i));
      end

      // Flush at beat 3 of an op that would otherwise clear o_cmp.
      start_op(vecs[2], "flush");
      for (int b = 0; b < 3; b++) begin
         bus.i_en = 1'b1;
         drive_beat(vecs[2], b);
         @(posedge clk);
         @(negedge clk);
      end
      bus.i_en    = 1'b1;
      bus.i_flush = 1'b1;
      drive_beat(vecs[2], 3);
      @(posedge clk);
      @(negedge clk);
      bus.i_flush = 1'b0;
      bus.i_en    = 1'b0;
      #1;
      chk("flush busy", 32'(bus.o_busy), 32'd0);
      chk("flush done", 32'(bus.o_done), 32'd0);
      chk("flush cmp held", 32'(bus.o_cmp), 32'd1);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("flush no late done", 32'(bus.o_done), 32'd0);

      // New op after flush, then back-to-back starts issued in the DONE cycle.
      start_op(vecs[2], "post_flush");
      run_beats(vecs[2], "post_flush");
      start_op(vecs[1], "b2b1");
      run_beats(vecs[1], "b2b1");
      start_op(vecs[5], "b2b2");
      run_beats(vecs[5], "b2b2");
      idle_after("b2b2");

      // Asynchronous reset in the middle of beat 5.
      start_op(vecs[4], "pre_rst");
      run_beats(vecs[4], "pre_rst");
      idle_after("pre_rst");
      start_op(vecs[6], "mid_rst");
      for (int b = 0; b < 5; b++) begin
         bus.i_en = 1'b1;
         drive_beat(vecs[6], b);
         @(posedge clk);
         @(negedge clk);
      end
      bus.i_en  = 1'b1;
      drive_beat(vecs[6], 5);
      bus.i_buf = 4'hF;
      #1;
      chk("mid_rst busy before", 32'(bus.o_busy), 32'd1);
      i_rst_n = 1'b0;
      #1;
      chk("mid_rst rd", 32'(bus.o_rd), 32'd0);
      chk("mid_rst busy", 32'(bus.o_busy), 32'd0);
      chk("mid_rst cnt0", 32'(bus.o_cnt0), 32'd0);
      chk("mid_rst last", 32'(bus.o_last), 32'd0);
      chk("mid_rst done", 32'(bus.o_done), 32'd0);
      chk("mid_rst cmp", 32'(bus.o_cmp), 32'd0);
      @(negedge clk);
      i_rst_n  = 1'b1;
      bus.i_en = 1'b0;
      bus.i_buf = '0;
      @(negedge clk);
      start_op(vecs[0], "post_rst");
      run_beats(vecs[0], "post_rst");
      idle_after("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
